i2c_reg_bank: RTL and testbench

I2C_REG_BANK -- requirements
Module: i2c_reg_bank

---
 rtl/i2c_reg_bank.sv | 126 ++++++++++++
 tb/tb_i2c_reg_bank.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_bank.sv
// Register bank behind an I2C slave: ID/version, control/status, LED and switch
// registers, scratch space and a fabric-fed RX FIFO popped by reading DATA.
module i2c_reg_bank #(
  parameter logic [7:0] DEVICE_ID  = 8'hA5,
  parameter logic [7:0] VERSION    = 8'h01,
  parameter int         FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_wdata,
  input  logic       reg_wr,
  input  logic       reg_rd,
  output logic [7:0] reg_rdata,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic [7:0] sw_in,
  output logic [7:0] led_out,
  output logic       irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [7:0] A_ID     = 8'h00;
  localparam logic [7:0] A_VER    = 8'h01;
  localparam logic [7:0] A_CTRL   = 8'h02;
  localparam logic [7:0] A_STATUS = 8'h03;
  localparam logic [7:0] A_LED    = 8'h04;
  localparam logic [7:0] A_SW     = 8'h05;
  localparam logic [7:0] A_COUNT  = 8'h06;
  localparam logic [7:0] A_DATA   = 8'h07;

  logic          irq_en, overflow;
  logic [7:0]    led;
  logic [7:0]    scratch [8];
  logic [7:0]    sw_s1, sw_s2;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          empty, full, push, pop, flush;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign rx_ready = !full;
  assign led_out  = led;

  assign push  = rx_valid && !full;
  assign pop   = reg_rd && (reg_addr == A_DATA) && !empty;
  assign flush = reg_wr && (reg_addr == A_CTRL) && reg_wdata[1];

  // Switch inputs are asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw_in;
      sw_s2 <= sw_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en   <= 1'b0;
      led      <= '0;
      overflow <= 1'b0;
      irq      <= 1'b0;
      for (int i = 0; i < 8; i++) scratch[i] <= '0;
    end else begin
      irq <= irq_en && (!empty || overflow);
      if (reg_wr) begin
        if (reg_addr == A_CTRL) irq_en <= reg_wdata[0];
        if (reg_addr == A_LED)  led    <= reg_wdata;
        if (reg_addr[7:3] == 5'b00001) scratch[reg_addr[2:0]] <= reg_wdata;
      end
      // A same-cycle overflow event beats the W1C clear.
      if (rx_valid && full)
        overflow <= 1'b1;
      else if (reg_wr && (reg_addr == A_STATUS) && reg_wdata[2])
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_comb begin
    reg_rdata = 8'h00;
    case (reg_addr)
      A_ID:     reg_rdata = DEVICE_ID;
      A_VER:    reg_rdata = VERSION;
      A_CTRL:   reg_rdata = {7'b0, irq_en};
      A_STATUS: reg_rdata = {5'b0, overflow, full, empty};
      A_LED:    reg_rdata = led;
      A_SW:     reg_rdata = sw_s2;
      A_COUNT:  reg_rdata = 8'(count);
      A_DATA:   reg_rdata = empty ? 8'h00 : mem[rd_ptr];
      default:  if (reg_addr[7:3] == 5'b00001) reg_rdata = scratch[reg_addr[2:0]];
    endcase
  end

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Bench for i2c_reg_bank: register accesses plus a byte queue scoreboard that
// mirrors what the RX FIFO should hold and predicts every DATA read.
module tb_i2c_reg_bank;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] reg_addr, reg_wdata, reg_rdata, rx_data, sw_in, led_out;
  logic       reg_wr, reg_rd, rx_valid, rx_ready, irq;

  int checks = 0;
  int fails  = 0;
  logic [7:0] sb [$];
  logic [7:0] d;

  i2c_reg_bank #(.DEVICE_ID(8'hA5), .VERSION(8'h01), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_rdata(reg_rdata),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .sw_in(sw_in), .led_out(led_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] v);
    @(negedge clk);
    reg_addr = a; reg_wdata = v; reg_wr = 1'b1;
    @(negedge clk);
    reg_wr = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    @(negedge clk);
    reg_addr = a; reg_rd = 1'b1;
    #1 v = reg_rdata;
    @(negedge clk);
    reg_rd = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] v;
    rd(a, v);
    chk(tag, v, exp);
  endtask

  // DATA read: expected value comes off the scoreboard (0 when empty).
  task automatic rd_data(input string tag);
    logic [7:0] exp;
    logic [7:0] v;
    exp = (sb.size() == 0) ? 8'h00 : sb.pop_front();
    rd(8'h07, v);
    chk(tag, v, exp);
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b;
    if (rx_ready) sb.push_back(b);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; reg_addr = '0; reg_wdata = '0; reg_wr = 1'b0; reg_rd = 1'b0;
    rx_valid = 1'b0; rx_data = '0; sw_in = 8'h96;
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
    chk("rst_led", led_out, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rx_ready", {7'b0, rx_ready}, 8'h01);
    rd_chk("rst_status", 8'h03, 8'h01);
    rd_chk("rst_count", 8'h06, 8'h00);
    rd_chk("rst_ctrl", 8'h02, 8'h00);

    // ID / version / unmapped
    rd_chk("id", 8'h00, 8'hA5);
    rd_chk("ver", 8'h01, 8'h01);
    rd_chk("unmapped", 8'h2A, 8'h00);

    // LED / scratch / RO write ignored
    rd_chk("sw_sync", 8'h05, 8'h96);
    wr(8'h04, 8'h5C);
    wr(8'h0F, 8'h3E);
    wr(8'h05, 8'h00);
    chk("led_out", led_out, 8'h5C);
    rd_chk("led_reg", 8'h04, 8'h5C);
    rd_chk("scratch7", 8'h0F, 8'h3E);
    rd_chk("scratch0", 8'h08, 8'h00);
    rd_chk("sw_unchanged", 8'h05, 8'h96);
    wr(8'h00, 8'h12);
    rd_chk("id_ro", 8'h00, 8'hA5);

    // Basic FIFO order and empty read
    push(8'h11); push(8'h22); push(8'h33);
    rd_chk("count3", 8'h06, 8'h03);
    for (int i = 0; i < 4; i++) rd_data($sformatf("data%0d", i));
    rd_chk("count_empty", 8'h06, 8'h00);
    rd_chk("status_empty", 8'h03, 8'h01);

    // Fill, overflow, W1C
    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
    chk("full_rx_ready", {7'b0, rx_ready}, 8'h00);
    push(8'hEE);
    rd_chk("count_full", 8'h06, 8'h10);
    rd_chk("status_ovf", 8'h03, 8'h06);
    wr(8'h03, 8'h04);
    rd_chk("status_w1c", 8'h03, 8'h02);
    rd_data("full_head");
    rd_chk("count15", 8'h06, 8'h0F);
    wr(8'h02, 8'h02);
    sb.delete();
    rd_chk("flush_count", 8'h06, 8'h00);
    rd_data("flush_data");

    // Interrupt timing and flush with irq_en
    wr(8'h02, 8'h01);
    @(negedge clk);
    chk("irq_idle", {7'b0, irq}, 8'h00);
    push(8'h77);
    chk("irq_lag", {7'b0, irq}, 8'h00);
    @(negedge clk);
    chk("irq_set", {7'b0, irq}, 8'h01);
    wr(8'h02, 8'h03);
    sb.delete();
    rd_chk("irq_flush_count", 8'h06, 8'h00);
    rd_chk("ctrl_rb", 8'h02, 8'h01);
    chk("irq_clr", {7'b0, irq}, 8'h00);
    wr(8'h02, 8'h00);

    // Simultaneous push and pop at count=5
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    begin
      logic [7:0] exp;
      exp = sb.pop_front();
      @(negedge clk);
      rx_valid = 1'b1; rx_data = 8'hB5; reg_addr = 8'h07; reg_rd = 1'b1;
      sb.push_back(8'hB5);
      #1 chk("simul_head", reg_rdata, exp);
      @(negedge clk);
      rx_valid = 1'b0; reg_rd = 1'b0;
    end
    rd_chk("simul_count", 8'h06, 8'h05);
    for (int i = 0; i < 5; i++) rd_data($sformatf("simul_drain%0d", i));
    rd_chk("simul_empty", 8'h06, 8'h00);

    // Reset mid-stream with irq active
    wr(8'h02, 8'h01);
    wr(8'h04, 8'hC3);
    push(8'h01); push(8'h02);
    @(negedge clk);
    chk("pre_rst_irq", {7'b0, irq}, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_irq", {7'b0, irq}, 8'h00);
    chk("mid_rst_led", led_out, 8'h00);
    chk("mid_rst_ready", {7'b0, rx_ready}, 8'h01);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rd_data("rst_data");
    rd_chk("rst2_count", 8'h06, 8'h00);
    rd_chk("rst2_ctrl", 8'h02, 8'h00);
    rd_chk("rst2_scratch", 8'h0F, 8'h00);
    chk("rst2_led", led_out, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
